// File: rtl/v_p_trans_pkg.sv
// Shared constants and FSM state type for the virtual/physical translation controller.
package v_p_trans_pkg;

    // Privilege level encodings.
    localparam logic [1:0] PRV_U = 2'd0;
    localparam logic [1:0] PRV_S = 2'd1;
    localparam logic [1:0] PRV_M = 2'd3;

    // Controller FSM: idle and accepting requests, or sweeping TLB entries.
    typedef enum logic {
        StIdle,
        StFlush
    } state_e;

endpackage

// File: rtl/v_p_priv_decode.sv
// Per-port privilege resolution: effective privilege, S-mode flag and whether
// address translation applies to this request.
module v_p_priv_decode
    import v_p_trans_pkg::*;
#(
    parameter int unsigned VM_W = 5
) (
    input  logic            instruction_i,
    input  logic            passthrough_i,
    input  logic            mprv_i,
    input  logic [1:0]      mpp_i,
    input  logic [1:0]      prv_i,
    input  logic            debug_i,
    input  logic [VM_W-1:0] vm_i,
    output logic            priv_s_o,
    output logic            vm_enabled_o
);

    logic       do_mprv;
    logic [1:0] priv;

    // MPRV only redirects data accesses; fetches always use the current privilege.
    always_comb begin
        do_mprv      = mprv_i & ~instruction_i;
        priv         = do_mprv ? mpp_i : prv_i;
        priv_s_o     = (priv == PRV_S);
        vm_enabled_o = (vm_i != '0) & (priv <= PRV_S) & ~debug_i & ~passthrough_i;
    end

endmodule

// File: rtl/v_p_trans_ctrl.sv
// Translation request controller: registers per-port privilege/VM decisions and
// sweeps TLB entries on sfence or a change of VM mode, stalling requests meanwhile.
// Optional feature: define V_P_TRANS_PERF_EN to add a saturating flush counter.
module v_p_trans_ctrl
    import v_p_trans_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned VM_W        = 5
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_PORTS-1:0]           io_req_valid,
    input  logic [NUM_PORTS-1:0]           io_req_bits_instruction,
    input  logic [NUM_PORTS-1:0]           io_req_bits_passthrough,
    output logic [NUM_PORTS-1:0]           io_req_ready,
    input  logic                           io_ptw_status_mprv,
    input  logic [1:0]                     io_ptw_status_mpp,
    input  logic [1:0]                     io_ptw_status_prv,
    input  logic                           io_ptw_status_debug,
    input  logic [VM_W-1:0]                io_ptw_status_vm,
    input  logic                           io_sfence_valid,
    output logic [NUM_PORTS-1:0]           io_resp_valid,
    output logic [NUM_PORTS-1:0]           io_resp_priv_s,
    output logic [NUM_PORTS-1:0]           io_resp_vm_enabled,
    output logic                           io_flush_valid,
    output logic [$clog2(NUM_ENTRIES)-1:0] io_flush_idx,
`ifdef V_P_TRANS_PERF_EN
    output logic [15:0]                    io_flush_count,
`endif
    output logic                           io_busy
);

    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [VM_W-1:0]        vm_q;
    logic                   flush_trigger;
    logic [NUM_PORTS-1:0]   accept;
    logic [NUM_PORTS-1:0]   dec_priv_s;
    logic [NUM_PORTS-1:0]   dec_vm_en;
    logic [NUM_PORTS-1:0]   resp_valid_q;
    logic [NUM_PORTS-1:0]   resp_priv_s_q;
    logic [NUM_PORTS-1:0]   resp_vm_en_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        v_p_priv_decode #(
            .VM_W (VM_W)
        ) u_priv_decode (
            .instruction_i (io_req_bits_instruction[p]),
            .passthrough_i (io_req_bits_passthrough[p]),
            .mprv_i        (io_ptw_status_mprv),
            .mpp_i         (io_ptw_status_mpp),
            .prv_i         (io_ptw_status_prv),
            .debug_i       (io_ptw_status_debug),
            .vm_i          (io_ptw_status_vm),
            .priv_s_o      (dec_priv_s[p]),
            .vm_enabled_o  (dec_vm_en[p])
        );
    end

    // A VM-mode change is detected against last cycle's sampled mode.
    assign flush_trigger = io_sfence_valid | (vm_q != io_ptw_status_vm);

    // Next-state logic: a trigger in FLUSH restarts the sweep from entry 0.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (flush_trigger) begin
                    state_d = StFlush;
                    idx_d   = '0;
                end
            end
            StFlush: begin
                if (flush_trigger) begin
                    idx_d = '0;
                end else if (idx_q == IDX_LAST) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    // State, sweep index and VM-mode shadow registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            vm_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            vm_q    <= io_ptw_status_vm;
        end
    end

    assign io_busy        = (state_q == StFlush);
    assign io_flush_valid = io_busy;
    assign io_flush_idx   = idx_q;
    assign io_req_ready   = {NUM_PORTS{state_q == StIdle}};
    assign accept         = io_req_valid & io_req_ready;

    // Response registers: valid pulses once per accept, data holds between accepts.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q  <= '0;
            resp_priv_s_q <= '0;
            resp_vm_en_q  <= '0;
        end else begin
            resp_valid_q  <= accept;
            resp_priv_s_q <= (accept & dec_priv_s) | (~accept & resp_priv_s_q);
            resp_vm_en_q  <= (accept & dec_vm_en) | (~accept & resp_vm_en_q);
        end
    end

    assign io_resp_valid      = resp_valid_q;
    assign io_resp_priv_s     = resp_priv_s_q;
    assign io_resp_vm_enabled = resp_vm_en_q;

`ifdef V_P_TRANS_PERF_EN
    logic [15:0] flush_count_q;

    // Counts sweeps started from IDLE; restarts inside a sweep are not new flushes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_count_q <= '0;
        end else if ((state_q == StIdle) && flush_trigger && (flush_count_q != 16'hFFFF)) begin
            flush_count_q <= flush_count_q + 16'd1;
        end
    end

    assign io_flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_v_p_trans_ctrl.sv
// Self-checking bench for v_p_trans_ctrl with a response scoreboard.
module tb_v_p_trans_ctrl;

    localparam int unsigned NP = 2;
    localparam int unsigned NE = 8;
    localparam int unsigned VW = 5;
    localparam int unsigned IW = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [NP-1:0] req_valid, req_instr, req_pass, req_ready;
    logic          mprv, debug, sfence;
    logic [1:0]    mpp, prv;
    logic [VW-1:0] vm;
    logic [NP-1:0] resp_valid, resp_priv_s, resp_vm_en;
    logic          flush_valid, busy;
    logic [IW-1:0] flush_idx;
`ifdef V_P_TRANS_PERF_EN
    logic [15:0]   flush_count;
`endif

    typedef struct {
        int   port;
        logic priv_s;
        logic vm_en;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;

    v_p_trans_ctrl #(
        .NUM_PORTS   (NP),
        .NUM_ENTRIES (NE),
        .VM_W        (VW)
    ) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .io_req_valid            (req_valid),
        .io_req_bits_instruction (req_instr),
        .io_req_bits_passthrough (req_pass),
        .io_req_ready            (req_ready),
        .io_ptw_status_mprv      (mprv),
        .io_ptw_status_mpp       (mpp),
        .io_ptw_status_prv       (prv),
        .io_ptw_status_debug     (debug),
        .io_ptw_status_vm        (vm),
        .io_sfence_valid         (sfence),
        .io_resp_valid           (resp_valid),
        .io_resp_priv_s          (resp_priv_s),
        .io_resp_vm_enabled      (resp_vm_en),
        .io_flush_valid          (flush_valid),
        .io_flush_idx            (flush_idx),
`ifdef V_P_TRANS_PERF_EN
        .io_flush_count          (flush_count),
`endif
        .io_busy                 (busy)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic exp_t model(input int port, input logic instr, input logic pass);
        exp_t       e;
        logic [1:0] priv;
        priv     = (mprv && !instr) ? mpp : prv;
        e.port   = port;
        e.priv_s = (priv == 2'd1);
        e.vm_en  = (vm != '0) && (priv <= 2'd1) && !debug && !pass;
        return e;
    endfunction

    // Drive a request cycle and record what each accepted port must return.
    task automatic send(input logic [NP-1:0] v, input logic [NP-1:0] ins,
                        input logic [NP-1:0] ps);
        req_valid = v;
        req_instr = ins;
        req_pass  = ps;
        for (int p = 0; p < NP; p++) begin
            if (v[p]) sb.push_back(model(p, ins[p], ps[p]));
        end
    endtask

    task automatic settle();
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            n_checks++;
            n_fail++;
            $display("FAIL settle_timeout: busy=%b required 0 within 40 cycles", busy);
        end
    endtask

    task automatic test_reset();
        req_valid = '0; req_instr = '0; req_pass = '0;
        mprv = 0; mpp = 0; prv = 0; debug = 0; vm = 0; sfence = 0;
        rst_i = 1;
        tick();
        tick();
        rst_i = 0;
        exp_cnt = 0;
        n_checks++;
        if (req_ready !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b required 11", req_ready); end
        n_checks++;
        if (flush_valid !== 1'b0) begin n_fail++; $display("FAIL reset_flush_valid: got %b required 0", flush_valid); end
        n_checks++;
        if (flush_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d required 0", flush_idx); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++;
        if ({resp_valid, resp_priv_s, resp_vm_en} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_resp: got valid=%b priv_s=%b vm_en=%b required all 0",
                     resp_valid, resp_priv_s, resp_vm_en);
        end
`ifdef V_P_TRANS_PERF_EN
        n_checks++;
        if (flush_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d required 0", flush_count); end
`endif
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_stable_vm: busy=%b required 0", busy); end
    endtask

    task automatic test_translate();
        exp_t e;
        prv = 2'd1; mprv = 0; debug = 0; vm = 5'd8;
        tick();
        exp_cnt++;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL translate_vm_flush: busy=%b required 1", busy); end
        settle();
        send(2'b01, 2'b00, 2'b00);
        tick();
        req_valid = '0;
        n_checks++;
        if (resp_valid !== 2'b01) begin n_fail++; $display("FAIL translate_valid: got %b required 01", resp_valid); end
        for (int p = 0; p < NP; p++) begin
            if (resp_valid[p] === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (e.port != p || resp_priv_s[p] !== e.priv_s || resp_vm_en[p] !== e.vm_en) begin
                    n_fail++;
                    $display("FAIL translate_resp: port %0d priv_s=%b vm_en=%b required port %0d priv_s=%b vm_en=%b",
                             p, resp_priv_s[p], resp_vm_en[p], e.port, e.priv_s, e.vm_en);
                end
            end
        end
        tick();
        n_checks++;
        if (resp_valid !== 2'b00 || resp_priv_s[0] !== 1'b1 || resp_vm_en[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL translate_hold: valid=%b priv_s0=%b vm_en0=%b required 00 1 1",
                     resp_valid, resp_priv_s[0], resp_vm_en[0]);
        end
    endtask

    task automatic test_mprv();
        exp_t e;
        mprv = 1; mpp = 2'd3; prv = 2'd0;
        send(2'b11, 2'b10, 2'b00);
        tick();
        req_valid = '0;
        mprv = 0;
        n_checks++;
        if (resp_valid !== 2'b11) begin n_fail++; $display("FAIL mprv_valid: got %b required 11", resp_valid); end
        for (int p = 0; p < NP; p++) begin
            if (resp_valid[p] === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (e.port != p || resp_priv_s[p] !== e.priv_s || resp_vm_en[p] !== e.vm_en) begin
                    n_fail++;
                    $display("FAIL mprv_resp: port %0d priv_s=%b vm_en=%b required port %0d priv_s=%b vm_en=%b",
                             p, resp_priv_s[p], resp_vm_en[p], e.port, e.priv_s, e.vm_en);
                end
            end
        end
    endtask

    task automatic test_debug_passthrough();
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            debug = (s == 0);
            prv   = 2'd0;
            if (s == 0) send(2'b11, 2'b10, 2'b00);
            else        send(2'b11, 2'b00, 2'b10);
            tick();
            req_valid = '0;
            n_checks++;
            if (resp_valid !== 2'b11) begin n_fail++; $display("FAIL dbg_pass_valid: step %0d got %b required 11", s, resp_valid); end
            for (int p = 0; p < NP; p++) begin
                if (resp_valid[p] === 1'b1 && sb.size() > 0) begin
                    e = sb.pop_front();
                    n_checks++;
                    if (e.port != p || resp_priv_s[p] !== e.priv_s || resp_vm_en[p] !== e.vm_en) begin
                        n_fail++;
                        $display("FAIL dbg_pass_resp: step %0d port %0d priv_s=%b vm_en=%b required port %0d priv_s=%b vm_en=%b",
                                 s, p, resp_priv_s[p], resp_vm_en[p], e.port, e.priv_s, e.vm_en);
                    end
                end
            end
        end
        debug = 0;
    endtask

    task automatic test_flush();
        exp_t          e;
        logic [IW-1:0] ei;
        logic [NP-1:0] ev;
        // Request and sfence together: request still accepted.
        send(2'b01, 2'b00, 2'b00);
        sfence = 1;
        tick();
        sfence = 0;
        req_valid = 2'b11;
        exp_cnt++;
        for (int i = 0; i < int'(NE); i++) begin
            ei = IW'(i);
            ev = (i == 0) ? 2'b01 : 2'b00;
            n_checks++;
            if (flush_valid !== 1'b1 || flush_idx !== ei || req_ready !== 2'b00 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_cycle %0d: fv=%b idx=%0d ready=%b busy=%b required 1 %0d 00 1",
                         i, flush_valid, flush_idx, req_ready, busy, ei);
            end
            n_checks++;
            if (resp_valid !== ev) begin n_fail++; $display("FAIL flush_resp_valid %0d: got %b required %b", i, resp_valid, ev); end
            for (int p = 0; p < NP; p++) begin
                if (resp_valid[p] === 1'b1 && sb.size() > 0) begin
                    e = sb.pop_front();
                    n_checks++;
                    if (e.port != p || resp_priv_s[p] !== e.priv_s || resp_vm_en[p] !== e.vm_en) begin
                        n_fail++;
                        $display("FAIL flush_resp: port %0d priv_s=%b vm_en=%b required port %0d priv_s=%b vm_en=%b",
                                 p, resp_priv_s[p], resp_vm_en[p], e.port, e.priv_s, e.vm_en);
                    end
                end
            end
            tick();
        end
        req_valid = '0;
        n_checks++;
        if (busy !== 1'b0 || flush_valid !== 1'b0 || req_ready !== 2'b11 || resp_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_end: busy=%b fv=%b ready=%b resp_valid=%b required 0 0 11 00",
                     busy, flush_valid, req_ready, resp_valid);
        end
    endtask

    task automatic test_flush_restart();
        logic [IW-1:0] ei;
        sfence = 1;
        tick();
        sfence = 0;
        exp_cnt++;
        for (int i = 0; i <= 5; i++) begin
            ei = IW'(i);
            n_checks++;
            if (busy !== 1'b1 || flush_idx !== ei) begin
                n_fail++;
                $display("FAIL restart_pre %0d: busy=%b idx=%0d required 1 %0d", i, busy, flush_idx, ei);
            end
            if (i == 5) sfence = 1;
            tick();
        end
        sfence = 0;
        for (int i = 0; i < int'(NE); i++) begin
            ei = IW'(i);
            n_checks++;
            if (flush_valid !== 1'b1 || flush_idx !== ei) begin
                n_fail++;
                $display("FAIL restart_post %0d: fv=%b idx=%0d required 1 %0d", i, flush_valid, flush_idx, ei);
            end
            tick();
        end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_end: busy=%b required 0", busy); end
`ifdef V_P_TRANS_PERF_EN
        n_checks++;
        if (flush_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL restart_count: got %0d required %0d", flush_count, exp_cnt); end
`endif
    endtask

    task automatic test_reset_mid_flush();
        vm = 5'd0;
        tick();
        exp_cnt++;
        settle();
        vm = 5'd8;
        tick();
        exp_cnt++;
        n_checks++;
        if (busy !== 1'b1 || flush_idx !== 3'd0) begin n_fail++; $display("FAIL vmchg_start: busy=%b idx=%0d required 1 0", busy, flush_idx); end
        tick(); tick(); tick();
        n_checks++;
        if (flush_idx !== 3'd3) begin n_fail++; $display("FAIL vmchg_idx3: got %0d required 3", flush_idx); end
        rst_i = 1;
        tick();
        rst_i = 0;
        exp_cnt = 0;
        n_checks++;
        if (busy !== 1'b0 || flush_valid !== 1'b0 || flush_idx !== 3'd0 || resp_valid !== 2'b00 || req_ready !== 2'b11) begin
            n_fail++;
            $display("FAIL midreset: busy=%b fv=%b idx=%0d resp_valid=%b ready=%b required 0 0 0 00 11",
                     busy, flush_valid, flush_idx, resp_valid, req_ready);
        end
        // Shadow VM is 0 after reset, so vm=8 retriggers a sweep.
        tick();
        exp_cnt++;
        n_checks++;
        if (busy !== 1'b1 || flush_idx !== 3'd0) begin n_fail++; $display("FAIL post_reset_vm: busy=%b idx=%0d required 1 0", busy, flush_idx); end
`ifdef V_P_TRANS_PERF_EN
        n_checks++;
        if (flush_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL post_reset_count: got %0d required %0d", flush_count, exp_cnt); end
`endif
        settle();
    endtask

    initial begin
        rst_i = 1;
        test_reset();
        test_translate();
        test_mprv();
        test_debug_passthrough();
        test_flush();
        test_flush_restart();
        test_reset_mid_flush();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
